// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding from the EX/MEM and MEM/WB
// writers. While stalled, the held operands keep refreshing from forwarding so
// a stalled instruction still picks up results that retire underneath it.
module id_ex_operand_stage #(
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_valid,
    input  logic [3:0]  i_alu_operation,
    input  logic [31:0] i_read_data1,
    input  logic [31:0] i_read_data2,
    input  logic [31:0] i_immediate,
    input  logic        i_alu_src,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic        i_reg_write,
    input  logic        i_exmem_reg_write,
    input  logic [4:0]  i_exmem_rd,
    input  logic [31:0] i_exmem_result,
    input  logic        i_memwb_reg_write,
    input  logic [4:0]  i_memwb_rd,
    input  logic [31:0] i_memwb_data,
    output logic [3:0]  o_alu_operation,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_store_data,
    output logic [4:0]  o_rd,
    output logic        o_reg_write,
    output logic        o_valid
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 4;

    logic [OP_W-1:0]   r_alu_operation;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_store_data;
    logic [REG_W-1:0]  r_rd;
    logic              r_reg_write;
    logic              r_valid;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic              r_alu_src;

    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;
    logic [DATA_W-1:0] w_hold_a;
    logic [DATA_W-1:0] w_hold_rt;

    // Select the newest in-flight value of a source register; $0 is never forwarded.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [REG_W-1:0]  src,
        input logic [DATA_W-1:0] fallback,
        input logic              exmem_we,
        input logic [REG_W-1:0]  exmem_rd,
        input logic [DATA_W-1:0] exmem_val,
        input logic              memwb_we,
        input logic [REG_W-1:0]  memwb_rd,
        input logic [DATA_W-1:0] memwb_val
    );
        logic [DATA_W-1:0] res;
        res = fallback;
        if (FORWARD_EN && (src != REG_W'(0))) begin
            if (exmem_we && (exmem_rd == src))
                res = exmem_val;
            else if (memwb_we && (memwb_rd == src))
                res = memwb_val;
        end
        return res;
    endfunction

    // Forwarded operands for the incoming instruction and for the held one.
    always_comb begin
        w_fwd_rs  = fwd(i_rs, i_read_data1, i_exmem_reg_write, i_exmem_rd, i_exmem_result,
                        i_memwb_reg_write, i_memwb_rd, i_memwb_data);
        w_fwd_rt  = fwd(i_rt, i_read_data2, i_exmem_reg_write, i_exmem_rd, i_exmem_result,
                        i_memwb_reg_write, i_memwb_rd, i_memwb_data);
        w_hold_a  = fwd(r_rs, r_a, i_exmem_reg_write, i_exmem_rd, i_exmem_result,
                        i_memwb_reg_write, i_memwb_rd, i_memwb_data);
        w_hold_rt = fwd(r_rt, r_store_data, i_exmem_reg_write, i_exmem_rd, i_exmem_result,
                        i_memwb_reg_write, i_memwb_rd, i_memwb_data);
    end

    // Pipeline register: reset/flush/invalid load a bubble, stall refreshes, else capture.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_alu_operation <= '0;
            r_a             <= '0;
            r_b             <= '0;
            r_store_data    <= '0;
            r_rd            <= '0;
            r_reg_write     <= 1'b0;
            r_valid         <= 1'b0;
            r_rs            <= '0;
            r_rt            <= '0;
            r_alu_src       <= 1'b0;
        end else if (i_flush || (!i_stall && !i_valid)) begin
            r_alu_operation <= '0;
            r_a             <= '0;
            r_b             <= '0;
            r_store_data    <= '0;
            r_rd            <= '0;
            r_reg_write     <= 1'b0;
            r_valid         <= 1'b0;
            r_rs            <= '0;
            r_rt            <= '0;
            r_alu_src       <= 1'b0;
        end else if (i_stall) begin
            r_a          <= w_hold_a;
            r_store_data <= w_hold_rt;
            if (!r_alu_src)
                r_b <= w_hold_rt;
        end else begin
            r_alu_operation <= i_alu_operation;
            r_a             <= w_fwd_rs;
            r_b             <= i_alu_src ? i_immediate : w_fwd_rt;
            r_store_data    <= w_fwd_rt;
            r_rd            <= i_rd;
            r_reg_write     <= i_reg_write & i_valid;
            r_valid         <= i_valid;
            r_rs            <= i_rs;
            r_rt            <= i_rt;
            r_alu_src       <= i_alu_src;
        end
    end

    assign o_alu_operation = r_alu_operation;
    assign o_a             = r_a;
    assign o_b             = r_b;
    assign o_store_data    = r_store_data;
    assign o_rd            = r_rd;
    assign o_reg_write     = r_reg_write;
    assign o_valid         = r_valid;

endmodule
